sram_axi_bridge: RTL and testbench

Parametrised bridge that merges NUM_CH sram-like request channels (instruction fetch, data access, and future cache refill ports) onto a single AXI3 master. It replaces the fixed two-port sram wiring at the CPU top level: the core keeps its sram-like handshake, and the bridge arbitrates, issues single-beat AXI reads and writes, and returns completion per channel. One transaction is outstanding at a time.

---
 rtl/bridge_pkg.sv | 34 +++
 rtl/sram_axi_bridge_arb.sv | 57 +++++
 rtl/sram_axi_bridge.sv | 183 ++++++++++++++++++
 tb/tb_sram_axi_bridge.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bridge_pkg.sv
// Shared types for the sram-to-AXI3 bridge: FSM states, AXI constants,
// and the latched request bundle.
package bridge_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_AR,
    S_R,
    S_AW_W,
    S_B
  } state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_1B = 3'd0;
  localparam logic [2:0] AXI_SIZE_2B = 3'd1;
  localparam logic [2:0] AXI_SIZE_4B = 3'd2;
  localparam logic [2:0] AXI_SIZE_8B = 3'd3;

  localparam int ID_W = 4;
  localparam int REQ_ADDR_W = 64;
  localparam int REQ_DATA_W = 64;
  localparam int REQ_STRB_W = REQ_DATA_W / 8;

  // Sized for the widest build; the top uses the low bits.
  typedef struct packed {
    logic                  wr;
    logic [2:0]            size;
    logic [REQ_ADDR_W-1:0] addr;
    logic [REQ_DATA_W-1:0] wdata;
    logic [REQ_STRB_W-1:0] wstrb;
    logic [ID_W-1:0]       grant;
  } req_t;

endpackage

// File: rtl/sram_axi_bridge_arb.sv
// NUM_CH-way arbiter, one-hot grant. BRIDGE_RR_ARB_EN selects
// round-robin; otherwise fixed priority with the lowest index winning.
module rr_arbiter
  import bridge_pkg::*;
#(
  parameter int NUM_CH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] req,
  input  logic              accept,
  output logic [NUM_CH-1:0] gnt,
  output logic [ID_W-1:0]   gnt_idx
);

  logic [ID_W-1:0] ptr_q;
  logic [ID_W-1:0] ptr_d;
  logic [ID_W-1:0] base;

`ifdef BRIDGE_RR_ARB_EN
  assign base = ptr_q;
`else
  logic unused_ptr;
  assign base = '0;
  assign unused_ptr = ^ptr_q;
`endif

  // Walk from the lowest priority up so the highest one is written last.
  always_comb begin
    int c;
    gnt = '0;
    gnt_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      c = int'(base) + i;
      if (c >= NUM_CH) c = c - NUM_CH;
      if (req[c]) begin
        gnt = '0;
        gnt[c] = 1'b1;
        gnt_idx = ID_W'(c);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (accept) begin
      if (gnt_idx == ID_W'(NUM_CH - 1)) ptr_d = '0;
      else ptr_d = gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else ptr_q <= ptr_d;
  end

endmodule

// File: rtl/sram_axi_bridge.sv
// Merges NUM_CH sram-like channels onto one AXI3 master, single beat,
// one transaction outstanding. Arbitration mode: BRIDGE_RR_ARB_EN.
module sram_axi_bridge
  import bridge_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [NUM_CH-1:0]          ch_req,
  input  logic [NUM_CH-1:0]          ch_wr,
  input  logic [NUM_CH*3-1:0]        ch_size,
  input  logic [NUM_CH*ADDR_W-1:0]   ch_addr,
  input  logic [NUM_CH*DATA_W-1:0]   ch_wdata,
  input  logic [NUM_CH*DATA_W/8-1:0] ch_wstrb,
  output logic [NUM_CH-1:0]          ch_addr_ok,
  output logic [NUM_CH-1:0]          ch_data_ok,
  output logic [DATA_W-1:0]          ch_rdata,
  output logic [3:0]                 arid,
  output logic [ADDR_W-1:0]          araddr,
  output logic [3:0]                 arlen,
  output logic [2:0]                 arsize,
  output logic [1:0]                 arburst,
  output logic                       arvalid,
  input  logic                       arready,
  input  logic [3:0]                 rid,
  input  logic [DATA_W-1:0]          rdata,
  input  logic [1:0]                 rresp,
  input  logic                       rlast,
  input  logic                       rvalid,
  output logic                       rready,
  output logic [3:0]                 awid,
  output logic [ADDR_W-1:0]          awaddr,
  output logic [3:0]                 awlen,
  output logic [2:0]                 awsize,
  output logic [1:0]                 awburst,
  output logic                       awvalid,
  input  logic                       awready,
  output logic [3:0]                 wid,
  output logic [DATA_W-1:0]          wdata,
  output logic [DATA_W/8-1:0]        wstrb,
  output logic                       wlast,
  output logic                       wvalid,
  input  logic                       wready,
  input  logic [3:0]                 bid,
  input  logic [1:0]                 bresp,
  input  logic                       bvalid,
  output logic                       bready
);

  localparam int STRB_W = DATA_W / 8;

  state_e state_q, state_d;
  req_t   req_q, req_d, sel;
  logic   arvalid_q, arvalid_d;
  logic   aw_pend_q, aw_pend_d;
  logic   w_pend_q, w_pend_d;

  logic [NUM_CH-1:0] gnt;
  logic [ID_W-1:0]   gnt_idx;
  logic              accept;
  logic              done;

  assign accept = (state_q == S_IDLE) && (|ch_req);

  rr_arbiter #(
    .NUM_CH(NUM_CH)
  ) u_arb (
    .clk    (clk),
    .rst_n  (resetn),
    .req    (ch_req),
    .accept (accept),
    .gnt    (gnt),
    .gnt_idx(gnt_idx)
  );

  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (gnt[i]) begin
        sel.wr = ch_wr[i];
        sel.size = ch_size[i*3 +: 3];
        sel.addr[ADDR_W-1:0] = ch_addr[i*ADDR_W +: ADDR_W];
        sel.wdata[DATA_W-1:0] = ch_wdata[i*DATA_W +: DATA_W];
        sel.wstrb[STRB_W-1:0] = ch_wstrb[i*STRB_W +: STRB_W];
      end
    end
    sel.grant = gnt_idx;
  end

  always_comb begin
    state_d = state_q;
    req_d = req_q;
    arvalid_d = arvalid_q;
    aw_pend_d = aw_pend_q;
    w_pend_d = w_pend_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          req_d = sel;
          if (sel.wr) begin
            state_d = S_AW_W;
            aw_pend_d = 1'b1;
            w_pend_d = 1'b1;
          end else begin
            state_d = S_AR;
            arvalid_d = 1'b1;
          end
        end
      end
      S_AR: begin
        if (arready) begin
          arvalid_d = 1'b0;
          state_d = S_R;
        end
      end
      S_R: begin
        if (rvalid && rlast) state_d = S_IDLE;
      end
      S_AW_W: begin
        if (awready) aw_pend_d = 1'b0;
        if (wready) w_pend_d = 1'b0;
        if (!aw_pend_d && !w_pend_d) state_d = S_B;
      end
      S_B: begin
        if (bvalid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      req_q     <= '0;
      arvalid_q <= 1'b0;
      aw_pend_q <= 1'b0;
      w_pend_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      arvalid_q <= arvalid_d;
      aw_pend_q <= aw_pend_d;
      w_pend_q  <= w_pend_d;
    end
  end

  assign done = ((state_q == S_R) && rvalid && rlast) ||
                ((state_q == S_B) && bvalid);

  assign ch_addr_ok = accept ? gnt : '0;
  assign ch_data_ok = done ? (NUM_CH'(1) << req_q.grant) : '0;
  assign ch_rdata = ((state_q == S_R) && rvalid) ? rdata : '0;

  assign arid    = req_q.grant;
  assign araddr  = req_q.addr[ADDR_W-1:0];
  assign arlen   = 4'd0;
  assign arsize  = req_q.size;
  assign arburst = AXI_BURST_INCR;
  assign arvalid = arvalid_q;
  assign rready  = (state_q == S_R);

  assign awid    = req_q.grant;
  assign awaddr  = req_q.addr[ADDR_W-1:0];
  assign awlen   = 4'd0;
  assign awsize  = req_q.size;
  assign awburst = AXI_BURST_INCR;
  assign awvalid = aw_pend_q;

  assign wid    = req_q.grant;
  assign wdata  = req_q.wdata[DATA_W-1:0];
  assign wstrb  = req_q.wstrb[STRB_W-1:0];
  assign wlast  = 1'b1;
  assign wvalid = w_pend_q;
  assign bready = (state_q == S_B);

  // Responses carry no information the core uses; errors complete normally.
  logic unused_ok;
  assign unused_ok = ^{rid, rresp, bid, bresp, req_q};

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Directed bench for sram_axi_bridge: vector table plus stall, reset,
// arbitration and error-response sequences.
module tb_sram_axi_bridge;

  logic        clk = 1'b0;
  logic        resetn;
  logic [1:0]  ch_req, ch_wr;
  logic [5:0]  ch_size;
  logic [63:0] ch_addr, ch_wdata;
  logic [7:0]  ch_wstrb;
  logic [1:0]  ch_addr_ok, ch_data_ok;
  logic [31:0] ch_rdata;
  logic [3:0]  arid, arlen, awid, awlen, wid, rid, bid;
  logic [31:0] araddr, awaddr, wdata, rdata;
  logic [2:0]  arsize, awsize;
  logic [1:0]  arburst, awburst, rresp, bresp;
  logic [3:0]  wstrb;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready;
  logic        bvalid, bready;

  int tests = 0;
  int fails = 0;
  int bhs = 0;

  always #5 clk = ~clk;

  sram_axi_bridge dut (
    .clk(clk), .resetn(resetn),
    .ch_req(ch_req), .ch_wr(ch_wr), .ch_size(ch_size),
    .ch_addr(ch_addr), .ch_wdata(ch_wdata), .ch_wstrb(ch_wstrb),
    .ch_addr_ok(ch_addr_ok), .ch_data_ok(ch_data_ok),
    .ch_rdata(ch_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always @(posedge clk) if (bready && bvalid) bhs <= bhs + 1;

  typedef struct {
    logic        wr;
    int          ch;
    logic [31:0] addr;
    logic [31:0] wdat;
    logic [3:0]  strb;
    logic [31:0] rdat;
    logic [1:0]  exp_ok;
    logic [3:0]  exp_id;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int c, input logic wr,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s);
    ch_req[c] = 1'b1;
    ch_wr[c] = wr;
    ch_size[c*3 +: 3] = 3'd2;
    ch_addr[c*32 +: 32] = a;
    ch_wdata[c*32 +: 32] = d;
    ch_wstrb[c*4 +: 4] = s;
  endtask

  initial begin
    logic [1:0] arb_exp[4];
    int b0;
    vec_t v;

    vecs[0] = '{1'b0, 0, 32'hBFC0_0000, 32'h0, 4'h0,
                32'h3C08_0001, 2'b01, 4'd0};
    vecs[1] = '{1'b1, 1, 32'h8000_1000, 32'hDEAD_BEEF, 4'hF,
                32'h0, 2'b10, 4'd1};
    vecs[2] = '{1'b0, 1, 32'h8000_1000, 32'h0, 4'h0,
                32'h1234_5678, 2'b10, 4'd1};
    vecs[3] = '{1'b1, 0, 32'h0000_0004, 32'hA5A5_A5A5, 4'h8,
                32'h0, 2'b01, 4'd0};
`ifdef BRIDGE_RR_ARB_EN
    arb_exp = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
    arb_exp = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif

    resetn = 1'b0;
    ch_req = '0; ch_wr = '0; ch_size = '0;
    ch_addr = '0; ch_wdata = '0; ch_wstrb = '0;
    arready = 1'b1; awready = 1'b1; wready = 1'b1;
    rvalid = 1'b0; rlast = 1'b0; rdata = '0; rid = '0; rresp = '0;
    bvalid = 1'b0; bid = '0; bresp = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ctl", {arvalid, awvalid, wvalid, rready, bready,
                      ch_addr_ok, ch_data_ok}, 64'h0);
    chk("reset_addr", {araddr, awaddr}, 64'h0);
    chk("reset_data", {wdata, arid, awid, wid, ch_rdata[19:0]}, 64'h0);
    resetn = 1'b1;
    cyc();

    for (int k = 0; k < 4; k++) begin
      v = vecs[k];
      set_ch(v.ch, v.wr, v.addr, v.wdat, v.strb);
      #1;
      chk("vec_addr_ok", ch_addr_ok, v.exp_ok);
      cyc();
      ch_req = '0;
      #1;
      if (!v.wr) begin
        chk("vec_ar", {arvalid, arsize, arid, araddr},
            {1'b1, 3'd2, v.exp_id, v.addr});
        chk("vec_ar_wait_ok", {ch_addr_ok, ch_data_ok}, 4'h0);
      end else begin
        chk("vec_aw", {awvalid, wvalid, awsize, awid, awaddr},
            {2'b11, 3'd2, v.exp_id, v.addr});
        chk("vec_w", {wid, wstrb, wdata}, {v.exp_id, v.strb, v.wdat});
      end
      cyc();
      if (!v.wr) begin
        rvalid = 1'b1; rlast = 1'b1; rdata = v.rdat;
      end else begin
        bvalid = 1'b1;
      end
      #1;
      chk("vec_data_ok", ch_data_ok, v.exp_ok);
      if (!v.wr) chk("vec_rdata", ch_rdata, v.rdat);
      cyc();
      rvalid = 1'b0; rlast = 1'b0; bvalid = 1'b0;
      #1;
      chk("vec_back_idle", {rready, bready, ch_data_ok}, 4'h0);
    end

    // Write with W accepted three cycles after AW.
    wready = 1'b0;
    set_ch(1, 1'b1, 32'h8000_1000, 32'hDEAD_BEEF, 4'b0011);
    #1;
    chk("split_addr_ok", ch_addr_ok, 2'b10);
    cyc();
    ch_req = '0;
    #1;
    chk("split_rise", {awvalid, wvalid}, 2'b11);
    cyc();
    chk("split_aw_done1", {awvalid, wvalid, bready}, 3'b010);
    cyc();
    chk("split_aw_done2", {awvalid, wvalid, wstrb}, {2'b01, 4'b0011});
    cyc();
    wready = 1'b1;
    #1;
    chk("split_w_hs", {awvalid, wvalid, ch_data_ok}, 4'b0100);
    cyc();
    b0 = bhs;
    chk("split_b_state", {bready, wvalid, ch_data_ok}, 4'b1000);
    bvalid = 1'b1;
    #1;
    chk("split_data_ok", ch_data_ok, 2'b10);
    cyc();
    bvalid = 1'b0;
    #1;
    chk("split_one_b", bhs - b0, 1);
    chk("split_idle", {bready, ch_data_ok}, 3'b000);

    // Both channels requesting back to back from a fresh pointer.
    resetn = 1'b0;
    #1;
    resetn = 1'b1;
    set_ch(0, 1'b0, 32'h0000_1000, 32'h0, 4'h0);
    set_ch(1, 1'b0, 32'h0000_2000, 32'h0, 4'h0);
    rvalid = 1'b1; rlast = 1'b1; rdata = 32'h55;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("arb_grant", ch_addr_ok, arb_exp[k]);
      cyc();
      cyc();
      chk("arb_data_ok", ch_data_ok, arb_exp[k]);
      cyc();
    end
    ch_req = '0; rvalid = 1'b0; rlast = 1'b0;
    cyc();

    // AR stalled for five cycles.
    arready = 1'b0;
    set_ch(0, 1'b0, 32'h0000_0100, 32'h0, 4'h0);
    #1;
    chk("stall_addr_ok", ch_addr_ok, 2'b01);
    cyc();
    ch_req = '0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("ar_stall", {arvalid, araddr, ch_addr_ok, ch_data_ok},
          {1'b1, 32'h0000_0100, 4'h0});
      cyc();
    end
    arready = 1'b1;
    #1;
    chk("stall_release", arvalid, 1'b1);
    cyc();
    rvalid = 1'b1; rlast = 1'b1; rdata = 32'hCAFE_0001;
    #1;
    chk("stall_data", {ch_data_ok, ch_rdata}, {2'b01, 32'hCAFE_0001});
    cyc();
    rvalid = 1'b0; rlast = 1'b0;

    // Reset while waiting in R.
    set_ch(0, 1'b0, 32'h0000_0200, 32'h0, 4'h0);
    #1;
    cyc();
    ch_req = '0;
    cyc();
    chk("rst_pre_r", {rready, arvalid}, 2'b10);
    resetn = 1'b0;
    #1;
    chk("rst_in_r", {arvalid, awvalid, wvalid, rready, bready,
                     ch_addr_ok, ch_data_ok}, 64'h0);
    chk("rst_in_r_addr", {araddr, arid}, 64'h0);
    resetn = 1'b1;
    set_ch(0, 1'b0, 32'h0000_0300, 32'h0, 4'h0);
    set_ch(1, 1'b0, 32'h0000_0400, 32'h0, 4'h0);
    #1;
    chk("rst_next_grant", ch_addr_ok, 2'b01);
    cyc();
    ch_req = '0;
    cyc();
    rvalid = 1'b1; rlast = 1'b1; rdata = 32'h77;
    #1;
    chk("rst_next_done", ch_data_ok, 2'b01);
    cyc();
    rvalid = 1'b0; rlast = 1'b0;

    // SLVERR on B still completes.
    set_ch(1, 1'b1, 32'h0000_0500, 32'h1, 4'hF);
    #1;
    cyc();
    ch_req = '0;
    cyc();
    bvalid = 1'b1; bresp = 2'b10;
    #1;
    chk("slverr_data_ok", ch_data_ok, 2'b10);
    cyc();
    bvalid = 1'b0; bresp = 2'b00;
    set_ch(0, 1'b0, 32'h0000_0600, 32'h0, 4'h0);
    #1;
    chk("slverr_idle", {ch_data_ok, ch_addr_ok, bready}, 5'b00010);
    ch_req = '0;
    cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
